// File: rtl/fp_sqrt_seq.sv
// fp_sqrt_seq: sequential floating-point square root over a shared bidirectional bus.
// One operand is captured from IO_DATA, classified, normalised, and square-rooted one
// root bit per cycle with a restoring digit recurrence. The result is rounded to
// nearest-even and driven back onto IO_DATA only while RESULT is high.
module fp_sqrt_seq #(
    parameter int EXP_W  = 5,
    parameter int MANT_W = 10
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    inout  wire  [EXP_W+MANT_W:0] IO_DATA,
    output logic                  IS_NAN,
    output logic                  IS_PINF,
    output logic                  IS_NINF,
    output logic                  RESULT
);

    localparam int W      = 1 + EXP_W + MANT_W;
    localparam int N      = MANT_W + 2;            // root bits: integer, fraction, guard
    localparam int REM_W  = N + 2;
    localparam int CAND_W = N + 4;
    localparam int EW     = EXP_W + 2;             // signed unbiased exponent, covers subnormals
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int LZ_W   = $clog2(MANT_W + 1);
    localparam int MS_W   = MANT_W + 1;

    localparam logic [W-1:0] QUIET_BIT  = {{(EXP_W + 1){1'b0}}, 1'b1, {(MANT_W - 1){1'b0}}};
    localparam logic [W-1:0] CANON_QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MANT_W - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, CLASS, NORM, ITER, ROUND, DONE} state_t;

    state_t state, state_nxt;

    logic        [W-1:0]      operand;
    logic        [2*N-1:0]    rad;
    logic        [N-1:0]      root;
    logic        [REM_W-1:0]  rem;
    logic signed [EW-1:0]     exp_r;
    logic        [CNT_W-1:0]  cnt;
    logic        [W-1:0]      res;
    logic                     nan_r;
    logic                     pinf_r;

    // Operand field decode
    logic              op_sign;
    logic [EXP_W-1:0]  op_exp;
    logic [MANT_W-1:0] op_mant;
    logic              exp_ones, exp_zero, mant_zero;

    assign op_sign   = operand[W-1];
    assign op_exp    = operand[W-2:MANT_W];
    assign op_mant   = operand[MANT_W-1:0];
    assign exp_ones  = &op_exp;
    assign exp_zero  = ~|op_exp;
    assign mant_zero = ~|op_mant;

    logic         is_special, spec_nan, spec_pinf;
    logic [W-1:0] spec_res;

    // Special-operand classification: zeros, NaNs, infinities and negative numbers
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        is_special = 1'b0;
        spec_res   = operand;
        spec_nan   = 1'b0;
        spec_pinf  = 1'b0;
        if (exp_ones && !mant_zero) begin
            is_special = 1'b1;
            spec_res   = operand | QUIET_BIT;
            spec_nan   = 1'b1;
        end else if (exp_zero && mant_zero) begin
            is_special = 1'b1;
        end else if (op_sign) begin
            is_special = 1'b1;
            spec_res   = CANON_QNAN;
            spec_nan   = 1'b1;
        end else if (exp_ones) begin
            is_special = 1'b1;
            spec_pinf  = 1'b1;
        end
    end

    logic        [LZ_W-1:0]   lzc;
    logic        [MANT_W:0]   norm_sig;
    logic signed [EW-1:0]     norm_exp;
    logic        [N-1:0]      rad_sig;
    logic signed [EW-1:0]     adj_exp;

    // Normalisation: hidden bit restored, subnormals shifted up, exponent forced even
    always_comb begin
        lzc = '0;
        for (int i = 0; i < MANT_W; i++) begin
            if (op_mant[i]) lzc = LZ_W'(MANT_W - 1 - i);
        end
        if (exp_zero) begin
            norm_sig = {1'b0, op_mant} << (lzc + LZ_W'(1));
            norm_exp = EW'(1 - BIAS) - EW'(lzc) - EW'(1);
        end else begin
            norm_sig = {1'b1, op_mant};
            norm_exp = EW'(op_exp) - EW'(BIAS);
        end
        if (norm_exp[0]) begin
            rad_sig = {norm_sig, 1'b0};
            adj_exp = norm_exp - EW'(1);
        end else begin
            rad_sig = {1'b0, norm_sig};
            adj_exp = norm_exp;
        end
    end

    logic [CAND_W-1:0] cand, sub;
    logic [REM_W-1:0]  rem_nxt;
    logic [N-1:0]      root_nxt;

    // One restoring square-root step: bring down two radicand bits, try root*4+1
    always_comb begin
        cand = {rem, rad[2*N-1 -: 2]};
        sub  = {2'b00, root, 2'b01};
        if (cand >= sub) begin
            rem_nxt  = REM_W'(cand - sub);
            root_nxt = {root[N-2:0], 1'b1};
        end else begin
            rem_nxt  = cand[REM_W-1:0];
            root_nxt = {root[N-2:0], 1'b0};
        end
    end

    logic              round_up;
    logic [MS_W-1:0]   mant_sum;
    logic [EXP_W-1:0]  rnd_exp;
    logic [W-1:0]      rnd_res;

    // Round to nearest-even from guard and sticky; mantissa carry bumps the exponent
    always_comb begin
        round_up = root[0] & ((|rem) | root[1]);
        mant_sum = {1'b0, root[N-2:1]} + MS_W'(round_up);
        rnd_exp  = EXP_W'((exp_r >>> 1) + EW'(BIAS)) + EXP_W'(mant_sum[MANT_W]);
        rnd_res  = {1'b0, rnd_exp, mant_sum[MANT_W-1:0]};
    end

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: ENABLE low in any busy state aborts back to IDLE
    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (ENABLE) state_nxt = CLASS;
        end else if (!ENABLE) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                CLASS:   state_nxt = is_special ? DONE : NORM;
                NORM:    state_nxt = ITER;
                ITER:    state_nxt = (cnt == CNT_W'(N - 1)) ? ROUND : ITER;
                ROUND:   state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath registers: capture, special result, recurrence and rounded result
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            operand <= '0;
            rad     <= '0;
            root    <= '0;
            rem     <= '0;
            exp_r   <= '0;
            cnt     <= '0;
            res     <= '0;
            nan_r   <= 1'b0;
            pinf_r  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ENABLE) operand <= IO_DATA;
                end
                CLASS: begin
                    res    <= spec_res;
                    nan_r  <= spec_nan;
                    pinf_r <= spec_pinf;
                end
                NORM: begin
                    rad   <= {rad_sig, {N{1'b0}}};
                    root  <= '0;
                    rem   <= '0;
                    exp_r <= adj_exp;
                    cnt   <= '0;
                end
                ITER: begin
                    rad  <= rad << 2;
                    root <= root_nxt;
                    rem  <= rem_nxt;
                    cnt  <= cnt + CNT_W'(1);
                end
                ROUND: begin
                    res    <= rnd_res;
                    nan_r  <= 1'b0;
                    pinf_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Outputs follow the state directly so reset clears them without waiting for an edge
    assign RESULT  = (state == DONE);
    assign IS_NAN  = RESULT & nan_r;
    assign IS_PINF = RESULT & pinf_r;
    assign IS_NINF = 1'b0;
    assign IO_DATA = RESULT ? res : {W{1'bz}};

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// tb_fp_sqrt_seq: directed vectors, multi-cycle corner sequences and random operands
// compared against a real-arithmetic square-root reference for the binary16 instance,
// plus a few binary32 vectors on a second instance.
module tb_fp_sqrt_seq;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RESET, ENABLE, ENABLE32;
    logic [15:0] drv16;
    logic [31:0] drv32;
    logic oe16, oe32;
    wire  [15:0] bus16;
    wire  [31:0] bus32;
    logic RESULT16, IS_NAN16, IS_PINF16, IS_NINF16;
    logic RESULT32, IS_NAN32, IS_PINF32, IS_NINF32;

    assign bus16 = oe16 ? drv16 : 16'hzzzz;
    assign bus32 = oe32 ? drv32 : 32'hzzzz_zzzz;

    fp_sqrt_seq #(.EXP_W(5), .MANT_W(10)) dut16 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .IO_DATA(bus16),
        .IS_NAN(IS_NAN16), .IS_PINF(IS_PINF16), .IS_NINF(IS_NINF16), .RESULT(RESULT16)
    );

    fp_sqrt_seq #(.EXP_W(8), .MANT_W(23)) dut32 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE32), .IO_DATA(bus32),
        .IS_NAN(IS_NAN32), .IS_PINF(IS_PINF32), .IS_NINF(IS_NINF32), .RESULT(RESULT32)
    );

    int checks;
    int errors;

    typedef struct {
        logic [15:0] op;
        logic [15:0] res;
        logic        nan;
        logic        pinf;
        int          lat;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: specials by rule, numbers via real sqrt then round-to-nearest-even to 11 bits
    function automatic void ref_sqrt16(input logic [15:0] x, output logic [15:0] r,
                                       output logic nan, output logic pinf, output int lat);
        int e, ex, ip;
        real v, t, sc, fr;
        e    = int'(x[14:10]);
        r    = x;
        nan  = 1'b0;
        pinf = 1'b0;
        lat  = 1;
        if (e == 31 && x[9:0] != 0) begin
            r   = x | 16'h0200;
            nan = 1'b1;
        end else if (e == 0 && x[9:0] == 0) begin
            r = x;
        end else if (x[15]) begin
            r   = 16'hFE00;
            nan = 1'b1;
        end else if (e == 31) begin
            pinf = 1'b1;
        end else begin
            lat = 15;
            if (e == 0) v = real'(int'(x[9:0])) * (2.0 ** (-24));
            else        v = real'(1024 + int'(x[9:0])) * (2.0 ** (e - 25));
            t  = $sqrt(v);
            ex = 0;
            while (t >= 2.0) begin t = t / 2.0; ex++; end
            while (t < 1.0)  begin t = t * 2.0; ex--; end
            sc = t * 1024.0;
            ip = int'($floor(sc));
            fr = sc - real'(ip);
            if (fr > 0.5 || (fr == 0.5 && (ip % 2) == 1)) ip++;
            if (ip == 2048) begin ip = 1024; ex++; end
            r = {1'b0, 5'(ex + 15), 10'(ip - 1024)};
        end
    endfunction

    task automatic do_op16(input logic [15:0] op, output logic [15:0] r, output logic nan,
                           output logic pinf, output logic ninf, output int lat, output logic leak);
        @(negedge CLK);
        drv16  = op;
        oe16   = 1'b1;
        ENABLE = 1'b1;
        @(negedge CLK);
        oe16 = 1'b0;
        lat  = -1;
        leak = RESULT16 | IS_NAN16 | IS_PINF16;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (RESULT16) begin
                lat = i;
                break;
            end
            if (IS_NAN16 || IS_PINF16) leak = 1'b1;
        end
        r    = bus16;
        nan  = IS_NAN16;
        pinf = IS_PINF16;
        ninf = IS_NINF16;
    endtask

    task automatic do_op32(input logic [31:0] op, output logic [31:0] r, output logic nan,
                           output int lat);
        @(negedge CLK);
        drv32    = op;
        oe32     = 1'b1;
        ENABLE32 = 1'b1;
        @(negedge CLK);
        oe32 = 1'b0;
        lat  = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK);
            if (RESULT32) begin
                lat = i;
                break;
            end
        end
        r   = bus32;
        nan = IS_NAN32;
        @(negedge CLK);
        ENABLE32 = 1'b0;
        @(negedge CLK);
    endtask

    task automatic end_op16(input string name);
        ENABLE = 1'b0;
        @(negedge CLK);
        check({name, "_drop"}, 32'(RESULT16), 32'd0);
    endtask

    // With the DUT released, a pattern driven by the bench must read back untouched
    task automatic check_released16(input string name);
        drv16 = 16'h0000;
        oe16  = 1'b1;
        #1;
        check(name, 32'(bus16), 32'h0000);
        oe16 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [15:0] r, x, exp_r;
        logic [31:0] r32;
        logic nan, pinf, ninf, leak, seen, exp_nan, exp_pinf;
        int lat, exp_lat;

        checks = 0;
        errors = 0;
        RESET = 1'b1; ENABLE = 1'b0; ENABLE32 = 1'b0;
        oe16 = 1'b0; oe32 = 1'b0; drv16 = '0; drv32 = '0;

        vecs[0] = '{16'h4400, 16'h4000, 1'b0, 1'b0, 15};
        vecs[1] = '{16'h4000, 16'h3DA8, 1'b0, 1'b0, 15};
        vecs[2] = '{16'h3C00, 16'h3C00, 1'b0, 1'b0, 15};
        vecs[3] = '{16'h0001, 16'h0C00, 1'b0, 1'b0, 15};
        vecs[4] = '{16'hBC00, 16'hFE00, 1'b1, 1'b0, 1};
        vecs[5] = '{16'h7C01, 16'h7E01, 1'b1, 1'b0, 1};
        vecs[6] = '{16'h7C00, 16'h7C00, 1'b0, 1'b1, 1};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1};
        vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1};
        vecs[9] = '{16'hFC00, 16'hFE00, 1'b1, 1'b0, 1};

        #3;
        check("reset_result", 32'(RESULT16), 32'd0);
        check("reset_nan",    32'(IS_NAN16),  32'd0);
        check("reset_pinf",   32'(IS_PINF16), 32'd0);
        check("reset_ninf",   32'(IS_NINF16), 32'd0);
        check("reset_result32", 32'(RESULT32), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        check_released16("reset_bus");

        // Directed vectors
        for (int i = 0; i < NV; i++) begin
            do_op16(vecs[i].op, r, nan, pinf, ninf, lat, leak);
            check($sformatf("vec%0d_data", i), 32'(r),    32'(vecs[i].res));
            check($sformatf("vec%0d_nan", i),  32'(nan),  32'(vecs[i].nan));
            check($sformatf("vec%0d_pinf", i), 32'(pinf), 32'(vecs[i].pinf));
            check($sformatf("vec%0d_ninf", i), 32'(ninf), 32'd0);
            check($sformatf("vec%0d_lat", i),  32'(lat),  32'(vecs[i].lat));
            check($sformatf("vec%0d_flags_early", i), 32'(leak), 32'd0);
            end_op16($sformatf("vec%0d", i));
            check_released16($sformatf("vec%0d_bus_release", i));
        end

        // Holding ENABLE high keeps the result and never restarts
        do_op16(16'h4000, r, nan, pinf, ninf, lat, leak);
        seen = 1'b0;
        repeat (25) begin
            @(negedge CLK);
            if (!RESULT16 || bus16 !== 16'h3DA8) seen = 1'b1;
        end
        check("hold_stable", 32'(seen), 32'd0);
        end_op16("hold");

        // Abort at edge 6 during ITER
        @(negedge CLK);
        drv16 = 16'h4400; oe16 = 1'b1; ENABLE = 1'b1;
        @(negedge CLK);
        oe16 = 1'b0;
        repeat (5) @(negedge CLK);
        ENABLE = 1'b0;
        @(negedge CLK);
        check("abort_result", 32'(RESULT16), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (RESULT16) seen = 1'b1;
        end
        check("abort_quiet", 32'(seen), 32'd0);
        check_released16("abort_bus");
        do_op16(16'h4400, r, nan, pinf, ninf, lat, leak);
        check("abort_next_data", 32'(r),   32'h4000);
        check("abort_next_lat",  32'(lat), 32'd15);
        end_op16("abort_next");

        // Reset between edges while in ITER, then a clean operation
        @(negedge CLK);
        drv16 = 16'h4000; oe16 = 1'b1; ENABLE = 1'b1;
        @(negedge CLK);
        oe16 = 1'b0;
        repeat (6) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        check("rst_iter_result", 32'(RESULT16), 32'd0);
        ENABLE = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        do_op16(16'h4000, r, nan, pinf, ninf, lat, leak);
        check("rst_iter_next_data", 32'(r),   32'h3DA8);
        check("rst_iter_next_lat",  32'(lat), 32'd15);
        end_op16("rst_iter_next");

        // Reset between edges while in DONE clears outputs without a clock edge
        do_op16(16'h7C00, r, nan, pinf, ninf, lat, leak);
        check("rst_done_pre_pinf", 32'(pinf), 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("rst_done_result", 32'(RESULT16),  32'd0);
        check("rst_done_pinf",   32'(IS_PINF16), 32'd0);
        check_released16("rst_done_bus");
        ENABLE = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        do_op16(16'h3C00, r, nan, pinf, ninf, lat, leak);
        check("rst_done_next_data", 32'(r),   32'h3C00);
        check("rst_done_next_lat",  32'(lat), 32'd15);
        end_op16("rst_done_next");

        // Random operands against the reference model (every other one forced subnormal)
        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom);
            if (i % 2 == 1) x[14:10] = 5'd0;
            ref_sqrt16(x, exp_r, exp_nan, exp_pinf, exp_lat);
            do_op16(x, r, nan, pinf, ninf, lat, leak);
            check($sformatf("rand%0d_data_op%04h", i, x), 32'(r),    32'(exp_r));
            check($sformatf("rand%0d_nan", i),            32'(nan),  32'(exp_nan));
            check($sformatf("rand%0d_pinf", i),           32'(pinf), 32'(exp_pinf));
            check($sformatf("rand%0d_lat", i),            32'(lat),  32'(exp_lat));
            end_op16($sformatf("rand%0d", i));
        end

        // Binary32 instance
        do_op32(32'h40800000, r32, nan, lat);
        check("f32_four_data", r32, 32'h40000000);
        check("f32_four_lat",  32'(lat), 32'd28);
        check("f32_four_nan",  32'(nan), 32'd0);
        do_op32(32'hBF800000, r32, nan, lat);
        check("f32_neg_data", r32, 32'hFFC00000);
        check("f32_neg_nan",  32'(nan), 32'd1);
        check("f32_neg_lat",  32'(lat), 32'd1);
        do_op32(32'h40000000, r32, nan, lat);
        check("f32_two_data", r32, 32'h3FB504F3);
        check("f32_two_lat",  32'(lat), 32'd28);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
